// File: rtl/tpu_vector_feeder.sv
// Operand sequencer for the 128-lane MAC array: fetches activation/weight words
// into two packed lane vectors, waits out the MAC settle window, captures the result.
//
// state  | meaning
// IDLE   | waiting for start; addresses parked at 0
// FETCH  | one read per cycle, issue index 0..VEC_LEN-1
// DRAIN  | last read returns and lands in lane VEC_LEN-1
// SETTLE | multicycle window for the dot-product chain, then capture
module tpu_vector_feeder #(
  parameter int WORD_W     = 16,
  parameter int VEC_LEN    = 128,
  parameter int ADDR_W     = 10,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         act_base,
  input  logic [ADDR_W-1:0]         wgt_base,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         act_addr,
  output logic [ADDR_W-1:0]         wgt_addr,
  input  logic [WORD_W-1:0]         act_rdata,
  input  logic [WORD_W-1:0]         wgt_rdata,
  output logic [VEC_LEN*WORD_W-1:0] vec_act,
  output logic [VEC_LEN*WORD_W-1:0] vec_wgt,
  input  logic [2*WORD_W-2:0]       mac_result,
  input  logic                      mac_overflow,
  output logic [2*WORD_W-2:0]       result,
  output logic                      result_ovf,
  output logic                      busy,
  output logic                      done
);

  localparam int LANE_W = $clog2(VEC_LEN);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(VEC_LEN - 1);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SETTLE} state_t;

  state_t              state;
  logic [LANE_W-1:0]   issue_k;
  logic [LANE_W-1:0]   rd_lane;
  logic                rd_valid;
  logic [SET_W-1:0]    settle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_k    <= '0;
      rd_lane    <= '0;
      rd_valid   <= 1'b0;
      settle_cnt <= '0;
      mem_rd     <= 1'b0;
      act_addr   <= '0;
      wgt_addr   <= '0;
      vec_act    <= '0;
      vec_wgt    <= '0;
      result     <= '0;
      result_ovf <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done     <= 1'b0;
      // Read data trails the strobe by one cycle; carry the lane index alongside.
      rd_valid <= mem_rd;
      rd_lane  <= issue_k;
      if (rd_valid) begin
        vec_act[int'(rd_lane)*WORD_W +: WORD_W] <= act_rdata;
        vec_wgt[int'(rd_lane)*WORD_W +: WORD_W] <= wgt_rdata;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            mem_rd   <= 1'b1;
            act_addr <= act_base;
            wgt_addr <= wgt_base;
            issue_k  <= '0;
          end
        end
        FETCH: begin
          if (issue_k == LAST_LANE) begin
            state    <= DRAIN;
            mem_rd   <= 1'b0;
            act_addr <= '0;
            wgt_addr <= '0;
          end else begin
            issue_k  <= issue_k + 1'b1;
            act_addr <= act_addr + 1'b1;
            wgt_addr <= wgt_addr + 1'b1;
          end
        end
        DRAIN: begin
          state      <= SETTLE;
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            result     <= mac_result;
            result_ovf <= mac_overflow;
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_vector_feeder.sv
// Scoreboard bench for tpu_vector_feeder: stimulus queues expected jobs,
// a negedge monitor checks addresses, counts, latency, vectors and results.
module tb_tpu_vector_feeder;

  localparam int WORD_W  = 16;
  localparam int VEC_LEN = 128;
  localparam int ADDR_W  = 10;
  localparam int RES_W   = 2*WORD_W-1;
  localparam int LATENCY = 132;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [ADDR_W-1:0]         act_base, wgt_base;
  logic                      mem_rd;
  logic [ADDR_W-1:0]         act_addr, wgt_addr;
  logic [WORD_W-1:0]         act_rdata, wgt_rdata;
  logic [VEC_LEN*WORD_W-1:0] vec_act, vec_wgt;
  logic [RES_W-1:0]          mac_result;
  logic                      mac_overflow;
  logic [RES_W-1:0]          result;
  logic                      result_ovf;
  logic                      busy, done;

  tpu_vector_feeder dut (
    .clk(clk), .rst(rst), .start(start), .act_base(act_base), .wgt_base(wgt_base),
    .mem_rd(mem_rd), .act_addr(act_addr), .wgt_addr(wgt_addr),
    .act_rdata(act_rdata), .wgt_rdata(wgt_rdata),
    .vec_act(vec_act), .vec_wgt(vec_wgt),
    .mac_result(mac_result), .mac_overflow(mac_overflow),
    .result(result), .result_ovf(result_ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WORD_W-1:0] act_mem [1<<ADDR_W];
  logic [WORD_W-1:0] wgt_mem [1<<ADDR_W];
  initial begin
    act_rdata = '0;
    wgt_rdata = '0;
    for (int a = 0; a < (1<<ADDR_W); a++) begin
      act_mem[a] = WORD_W'(a + 1);
      wgt_mem[a] = WORD_W'(16'h0100 + a);
    end
  end
  always @(posedge clk) begin
    if (mem_rd) begin
      act_rdata <= act_mem[act_addr];
      wgt_rdata <= wgt_mem[wgt_addr];
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] ab;
    logic [ADDR_W-1:0] wb;
    logic [RES_W-1:0]  res;
    logic              ovf;
    int                start_cyc;
  } job_t;

  job_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int busy_cnt = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: consumes the scoreboard whenever the DUT reads or completes.
  always @(negedge clk) begin
    job_t j;
    int bad_a, bad_w, first;
    logic [WORD_W-1:0] ea, ew;
    if (rst) begin
      exp_q.delete();
      rd_cnt   = 0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_rd) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd got mem_rd=1 exp no job (cycle %0d)", cyc);
        end else begin
          j = exp_q[0];
          chk("act_addr", 64'(act_addr), 64'(ADDR_W'(j.ab + ADDR_W'(rd_cnt))));
          chk("wgt_addr", 64'(wgt_addr), 64'(ADDR_W'(j.wb + ADDR_W'(rd_cnt))));
          rd_cnt++;
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done got done=1 exp no job (cycle %0d)", cyc);
        end else begin
          j = exp_q.pop_front();
          chk("latency", 64'(cyc - j.start_cyc), 64'(LATENCY));
          chk("result", 64'(result), 64'(j.res));
          chk("result_ovf", 64'(result_ovf), 64'(j.ovf));
          chk("busy_done_cycle", 64'(busy), 64'(0));
          chk("mem_rd_cycles", 64'(rd_cnt), 64'(VEC_LEN));
          chk("busy_cycles", 64'(busy_cnt), 64'(LATENCY - 1));
          bad_a = 0; bad_w = 0; first = -1;
          for (int k = 0; k < VEC_LEN; k++) begin
            ea = act_mem[ADDR_W'(j.ab + ADDR_W'(k))];
            ew = wgt_mem[ADDR_W'(j.wb + ADDR_W'(k))];
            if (vec_act[k*WORD_W +: WORD_W] !== ea) begin bad_a++; if (first < 0) first = k; end
            if (vec_wgt[k*WORD_W +: WORD_W] !== ew) begin bad_w++; if (first < 0) first = k; end
          end
          chk("vec_act_bad_lanes", 64'(bad_a), 64'(0));
          chk("vec_wgt_bad_lanes", 64'(bad_w), 64'(0));
          if (first >= 0)
            $display("  first bad lane %0d", first);
        end
        rd_cnt   = 0;
        busy_cnt = 0;
      end
    end
  end

  task automatic launch(input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] wb,
                        input logic [RES_W-1:0] res, input logic ovf);
    start    = 1'b1;
    act_base = ab;
    wgt_base = wb;
    exp_q.push_back('{ab: ab, wb: wb, res: res, ovf: ovf, start_cyc: cyc});
  endtask

  // Runs one job to its done cycle; returns with done visible.
  task automatic finish_job(input int inj, input bit hold,
                            input logic [RES_W-1:0] res, input logic ovf);
    int i;
    for (i = 1; i <= 200; i++) begin
      tick(1);
      if (i == 1 && !hold) start = 1'b0;
      if (i == inj) begin start = 1'b1; act_base = 10'd500; wgt_base = 10'd600; end
      if (i == inj + 1) start = 1'b0;
      if (i == 120) begin mac_result = res; mac_overflow = ovf; end
      if (done) break;
    end
    chk("done_within_bound", 64'(i <= 200), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; act_base = '0; wgt_base = '0;
    mac_result = '0; mac_overflow = 1'b0;
    tick(3);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_mem_rd", 64'(mem_rd), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_result_ovf", 64'(result_ovf), 64'(0));
    chk("rst_act_addr", 64'(act_addr), 64'(0));
    chk("rst_wgt_addr", 64'(wgt_addr), 64'(0));
    chk("rst_vec_act_nz", 64'(|vec_act), 64'(0));
    chk("rst_vec_wgt_nz", 64'(|vec_wgt), 64'(0));
    rst = 1'b0;
    tick(2);

    // Lane mapping and latency with base 0
    launch(10'd0, 10'd0, 31'h1234567, 1'b1);
    finish_job(-1, 1'b0, 31'h1234567, 1'b1);
    chk("lane5_act", 64'(vec_act[5*WORD_W +: WORD_W]), 64'h0006);
    chk("lane127_wgt", 64'(vec_wgt[127*WORD_W +: WORD_W]), 64'h017F);
    chk("idle_act_addr", 64'(act_addr), 64'(0));
    tick(3);

    // Address wrap
    launch(10'd1020, 10'd1000, 31'h0ABCDEF, 1'b0);
    finish_job(-1, 1'b0, 31'h0ABCDEF, 1'b0);
    chk("wrap_lane4_act", 64'(vec_act[4*WORD_W +: WORD_W]), 64'h0001);
    chk("wrap_lane0_act", 64'(vec_act[0 +: WORD_W]), 64'h03FD);
    tick(2);

    // Start mid-job is ignored
    launch(10'd10, 10'd20, 31'h7FFF0001, 1'b1);
    finish_job(60, 1'b0, 31'h7FFF0001, 1'b1);
    tick(140);
    chk("done_count_after_ignore", 64'(done_cnt), 64'(3));

    // Reset mid-job aborts
    launch(10'd3, 10'd4, 31'h1111111, 1'b0);
    tick(1);
    start = 1'b0;
    tick(49);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_mem_rd", 64'(mem_rd), 64'(0));
    chk("abort_vec_act_nz", 64'(|vec_act), 64'(0));
    chk("abort_vec_wgt_nz", 64'(|vec_wgt), 64'(0));
    tick(1);
    chk("abort_late_read_act_nz", 64'(|vec_act), 64'(0));
    chk("abort_late_read_wgt_nz", 64'(|vec_wgt), 64'(0));
    tick(150);
    chk("done_count_after_abort", 64'(done_cnt), 64'(3));

    // Normal job after abort
    launch(10'd7, 10'd9, 31'h2222222, 1'b1);
    finish_job(-1, 1'b0, 31'h2222222, 1'b1);
    tick(2);

    // Back-to-back: start held high across the first done cycle
    launch(10'd100, 10'd200, 31'h3333333, 1'b0);
    finish_job(-1, 1'b1, 31'h3333333, 1'b0);
    c0 = cyc;
    launch(10'd300, 10'd400, 31'h4444444, 1'b1);
    finish_job(-1, 1'b0, 31'h4444444, 1'b1);
    chk("b2b_second_done_gap", 64'(cyc - c0), 64'(LATENCY));
    chk("b2b_result", 64'(result), 64'(31'h4444444));
    tick(3);

    chk("done_count_total", 64'(done_cnt), 64'(6));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
